// File: rtl/filt_ppd.sv
// filt_ppd: polyphase FIR decimator.
// An N-tap sample delay line is split into M branches (branch k holds taps
// k, k+M, k+2M, ...). One output is produced per M accepted samples, on the
// accepted sample whose frame index equals gp_comm_phase.
// Optional build macro FILT_PPD_REG_OUT_EN adds a pipeline register after
// the adder tree, giving 2-cycle latency instead of 1. Both builds produce
// the same numerical results.
module filt_ppd #(
    parameter int gp_idata_width       = 8,
    parameter int gp_decimation_factor = 4,
    parameter int gp_coeff_length      = 16,
    parameter int gp_coeff_width       = 16,
    parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeffs = {
        16'd16, 16'd15, 16'd14, 16'd13, 16'd12, 16'd11, 16'd10, 16'd9,
        16'd8,  16'd7,  16'd6,  16'd5,  16'd4,  16'd3,  16'd2,  16'd1},
    parameter int gp_comm_phase        = 0,
    parameter int gp_odata_width       = 28
) (
    input  logic                      i_clk,
    input  logic                      i_rst_an,
    input  logic                      i_ena,
    input  logic [gp_idata_width-1:0] i_data,
    output logic [gp_odata_width-1:0] o_data,
    output logic                      o_sclk
);

    localparam int IW    = gp_idata_width;
    localparam int M     = gp_decimation_factor;
    localparam int N     = gp_coeff_length;
    localparam int CW    = gp_coeff_width;
    localparam int OW    = gp_odata_width;
    localparam int PW    = IW + CW;
    localparam int CNT_W = (M > 1) ? $clog2(M) : 1;

    // Illegal configurations stop elaboration.
    if (M < 2) begin : g_err_m
        $error("filt_ppd: gp_decimation_factor must be >= 2");
    end
    if (N < M) begin : g_err_n
        $error("filt_ppd: gp_coeff_length must be >= gp_decimation_factor");
    end
    if ((gp_comm_phase < 0) || (gp_comm_phase >= M)) begin : g_err_phase
        $error("filt_ppd: gp_comm_phase must lie in 0..gp_decimation_factor-1");
    end

    // Tap n coefficient as a signed value.
    function automatic logic signed [CW-1:0] coeff_at(input int n);
        return $signed(gp_coeffs[n*CW +: CW]);
    endfunction

    logic signed [IW-1:0] d_r      [N];
    logic signed [IW-1:0] d_next_s [N];
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_next_s;
    logic                 event_s;
    logic signed [PW-1:0] prod_s   [N];
    logic signed [OW-1:0] branch_s [M];
    logic signed [OW-1:0] y_s;

    // Delay line as it will look after the current sample is accepted.
    always_comb begin
        d_next_s[0] = $signed(i_data);
        for (int n = 1; n < N; n++) begin
            d_next_s[n] = d_r[n-1];
        end
    end

    // Frame counter advance and output-event detection on accepted samples.
    always_comb begin
        cnt_next_s = cnt_r;
        event_s    = 1'b0;
        if (i_ena) begin
            event_s = (cnt_r == CNT_W'(gp_comm_phase));
            if (cnt_r == CNT_W'(M - 1)) begin
                cnt_next_s = {CNT_W{1'b0}};
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Full-precision tap products, sign-extended into per-branch sums, then
    // branch sums added; the result wraps modulo 2^OW (MSBs dropped).
    always_comb begin
        for (int n = 0; n < N; n++) begin
            prod_s[n] = PW'(coeff_at(n)) * PW'(d_next_s[n]);
        end
        for (int k = 0; k < M; k++) begin
            branch_s[k] = {OW{1'b0}};
        end
        for (int n = 0; n < N; n++) begin
            branch_s[n % M] = branch_s[n % M] + OW'(prod_s[n]);
        end
        y_s = {OW{1'b0}};
        for (int k = 0; k < M; k++) begin
            y_s = y_s + branch_s[k];
        end
    end

    // Delay line and frame counter state; both hold while i_ena is low.
    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            for (int n = 0; n < N; n++) begin
                d_r[n] <= {IW{1'b0}};
            end
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
            if (i_ena) begin
                for (int n = 0; n < N; n++) begin
                    d_r[n] <= d_next_s[n];
                end
            end
        end
    end

`ifdef FILT_PPD_REG_OUT_EN
    logic signed [OW-1:0] y_r;
    logic                 vld_r;

    // Two-stage output: adder-tree register, then the output register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            y_r    <= {OW{1'b0}};
            vld_r  <= 1'b0;
            o_data <= {OW{1'b0}};
            o_sclk <= 1'b0;
        end else begin
            vld_r  <= event_s;
            o_sclk <= vld_r;
            if (event_s) begin
                y_r <= y_s;
            end
            if (vld_r) begin
                o_data <= y_r;
            end
        end
    end
`else
    // Single-stage output register; o_data holds between output events.
    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            o_data <= {OW{1'b0}};
            o_sclk <= 1'b0;
        end else begin
            o_sclk <= event_s;
            if (event_s) begin
                o_data <= y_s;
            end
        end
    end
`endif

endmodule
